// File: rtl/delay_tap_pkg.sv
// Shared constants and elaboration-time helpers for the delay tap generator.
// Sequence length and counter width are derived here so every user agrees on them.
package delay_tap_pkg;

    localparam int RETRIG_IGNORE  = 0;
    localparam int RETRIG_RESTART = 1;

    // Count value at which a sequence completes; the last tap is high again by then.
    function automatic int seq_last(input int ntaps, input int step, input int pw);
        return step * ntaps + pw;
    endfunction

    function automatic int cnt_width(input int ntaps, input int step, input int pw);
        return $clog2(seq_last(ntaps, step, pw) + 1);
    endfunction

    function automatic bit params_ok(input int ntaps, input int step, input int pw,
                                     input int sync_stages, input int retrig);
        return (ntaps >= 1) && (ntaps <= 16) && (step >= 1) && (pw >= 1) &&
               (sync_stages >= 0) && (sync_stages <= 3) &&
               ((retrig == RETRIG_IGNORE) || (retrig == RETRIG_RESTART));
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Optional synchroniser chain followed by a rising-edge detector on one input.
// The rise output is combinational from the last stage and its history flop.
module edge_sync #(
    parameter int SYNC_STAGES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic rise_o
);

    logic s;
    logic hist_q;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign s = d_i;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;

        // NOTE: sync and history flops reset to 1 so a trigger already high at
        // reset release is never seen as a rising edge.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync_q <= '1;
            end else begin
                sync_q[0] <= d_i;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
        end

        assign s = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= s;
        end
    end

    assign rise_o = s & ~hist_q;

endmodule

// File: rtl/delay_tap_gen.sv
// Trigger-launched chain of active-low tap pulses at fixed spacing and width,
// with retrigger policy, enable gating and busy/done/missed status.
module delay_tap_gen
    import delay_tap_pkg::*;
#(
    parameter int NTAPS       = 5,
    parameter int STEP        = 2,
    parameter int PW          = 2,
    parameter int SYNC_STAGES = 0,
    parameter int RETRIG      = RETRIG_IGNORE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             trig,
    input  logic             enable,
    output logic [NTAPS-1:0] tap_n,
    output logic             busy,
    output logic             done,
    output logic             missed
);

    localparam int            LAST   = seq_last(NTAPS, STEP, PW);
    localparam int            CW     = cnt_width(NTAPS, STEP, PW);
    localparam logic [CW-1:0] LAST_C = CW'(LAST);

    if (!params_ok(NTAPS, STEP, PW, SYNC_STAGES, RETRIG)) begin : g_bad_params
        $error("delay_tap_gen: parameter out of range");
    end

    logic             rise;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             missed_q, missed_d;
    logic [NTAPS-1:0] tap_q, tap_d;
    logic             at_last, accept, start;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (trig),
        .rise_o  (rise)
    );

    // An edge on the completing cycle is always taken; otherwise the policy decides.
    always_comb begin
        at_last = busy_q && (cnt_q == LAST_C);
        accept  = rise && enable;
        start   = accept && (!busy_q || at_last || (RETRIG == RETRIG_RESTART));
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        missed_d = accept && !start;
        tap_d    = '1;

        if (start) begin
            cnt_d  = CW'(1);
            busy_d = 1'b1;
            done_d = at_last;
        end else if (at_last) begin
            cnt_d  = '0;
            busy_d = 1'b0;
            done_d = 1'b1;
        end else if (busy_q) begin
            cnt_d = cnt_q + CW'(1);
        end

        // Tap k is low for the PW counts starting at STEP*(k+1); a restart forces all high.
        if (!start) begin
            for (int k = 0; k < NTAPS; k++) begin
                if (busy_q && (int'(cnt_q) >= STEP * (k + 1)) &&
                    (int'(cnt_q) < STEP * (k + 1) + PW)) begin
                    tap_d[k] = 1'b0;
                end
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so all of them update from
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            missed_q <= 1'b0;
            tap_q    <= '1;
        end else begin
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            missed_q <= missed_d;
            tap_q    <= tap_d;
        end
    end

    assign tap_n  = tap_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign missed = missed_q;

    a_done_missed_excl : assert property (@(posedge clk) disable iff (!reset_n)
        !(done_q && missed_q));

    a_tap_needs_busy : assert property (@(posedge clk) disable iff (!reset_n)
        (tap_q != '1) |-> busy_q);

endmodule

// File: tb/tb_delay_tap_gen.sv
// Directed bench for delay_tap_gen: default, restart-on-retrigger and
// two-stage-synchroniser instances driven from tables and short sequences.
module tb_delay_tap_gen;

    localparam int ND = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [ND-1:0] trig_v;
    logic [ND-1:0] en_v;
    logic [ND-1:0] busy_v;
    logic [ND-1:0] done_v;
    logic [ND-1:0] missed_v;
    logic [4:0]    tap0, tap1, tap2;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       trig;
        logic       en;
        logic [7:0] exp;   // {tap_n[4:0], busy, done, missed}
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    delay_tap_gen u_dut_def (
        .clk (clk), .reset_n (reset_n), .trig (trig_v[0]), .enable (en_v[0]),
        .tap_n (tap0), .busy (busy_v[0]), .done (done_v[0]), .missed (missed_v[0])
    );

    delay_tap_gen #(.RETRIG (1)) u_dut_rt (
        .clk (clk), .reset_n (reset_n), .trig (trig_v[1]), .enable (en_v[1]),
        .tap_n (tap1), .busy (busy_v[1]), .done (done_v[1]), .missed (missed_v[1])
    );

    delay_tap_gen #(.SYNC_STAGES (2)) u_dut_sync (
        .clk (clk), .reset_n (reset_n), .trig (trig_v[2]), .enable (en_v[2]),
        .tap_n (tap2), .busy (busy_v[2]), .done (done_v[2]), .missed (missed_v[2])
    );

    function automatic logic [7:0] obs(input int d);
        logic [4:0] t;
        case (d)
            0:       t = tap0;
            1:       t = tap1;
            default: t = tap2;
        endcase
        return {t, busy_v[d], done_v[d], missed_v[d]};
    endfunction

    function automatic int activity(input int d);
        return int'(busy_v[d]) + int'(done_v[d]) + int'(missed_v[d]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one instance's inputs, then advance past the next rising edge.
    task automatic cyc(input int d, input logic t, input logic e);
        trig_v[d] = t;
        en_v[d]   = e;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic t, input logic e, input logic [7:0] x);
        vec_t v;
        v.trig = t;
        v.en   = e;
        v.exp  = x;
        tbl.push_back(v);
    endtask

    task automatic add_n(input int n, input logic t, input logic e, input logic [7:0] x);
        for (int i = 0; i < n; i++) add(t, e, x);
    endtask

    initial begin
        int act_cnt;
        int done_cnt;

        trig_v  = '0;
        en_v    = '1;
        reset_n = 1'b0;
        #12;
        for (int d = 0; d < ND; d++) check($sformatf("reset_state[%0d]", d), obs(d), 8'b11111_000);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Single sequence; row n is the state after edge E+n.
        add_n(2, 1, 1, 8'b11111_100);
        add_n(2, 0, 1, 8'b11110_100);
        add_n(2, 0, 1, 8'b11101_100);
        add_n(2, 0, 1, 8'b11011_100);
        add_n(2, 0, 1, 8'b10111_100);
        add_n(2, 0, 1, 8'b01111_100);
        add  (   0, 1, 8'b11111_010);
        add  (   0, 1, 8'b11111_000);
        // Second rise at E+5 is dropped and flagged.
        add  (   1, 1, 8'b11111_100);
        add  (   0, 1, 8'b11111_100);
        add_n(2, 0, 1, 8'b11110_100);
        add  (   0, 1, 8'b11101_100);
        add  (   1, 1, 8'b11101_101);
        add  (   1, 1, 8'b11011_100);
        add  (   0, 1, 8'b11011_100);
        add_n(2, 0, 1, 8'b10111_100);
        add_n(2, 0, 1, 8'b01111_100);
        add  (   0, 1, 8'b11111_010);
        add  (   0, 1, 8'b11111_000);
        // Rise with enable low is consumed: holding trig high afterwards starts nothing.
        add  (   1, 0, 8'b11111_000);
        add  (   1, 1, 8'b11111_000);
        add  (   0, 1, 8'b11111_000);
        // Enable dropped mid-sequence: sequence completes, rise while disabled not missed.
        add  (   1, 1, 8'b11111_100);
        add  (   0, 0, 8'b11111_100);
        add  (   0, 0, 8'b11110_100);
        add  (   1, 0, 8'b11110_100);
        add_n(2, 0, 0, 8'b11101_100);
        add_n(2, 0, 0, 8'b11011_100);
        add_n(2, 0, 0, 8'b10111_100);
        add_n(2, 0, 0, 8'b01111_100);
        add  (   0, 0, 8'b11111_010);
        add  (   0, 1, 8'b11111_000);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(0, tbl[i].trig, tbl[i].en);
            check($sformatf("tbl[%0d]", i), obs(0), tbl[i].exp);
        end

        // Restart policy: rise at E+5 restarts, only the second sequence signals done.
        done_cnt = 0;
        for (int n = 0; n <= 18; n++) begin
            cyc(1, (n == 0) || (n == 5), 1'b1);
            done_cnt += int'(done_v[1]);
            case (n)
                4:  check("rt_e4",         obs(1), 8'b11101_100);
                5:  check("rt_e5_restart", obs(1), 8'b11111_100);
                7:  check("rt_e7_tap0",    obs(1), 8'b11110_100);
                12: check("rt_e12_nodone", obs(1), 8'b11011_100);
                16: check("rt_e16_tap4",   obs(1), 8'b01111_100);
                17: check("rt_e17_done",   obs(1), 8'b11111_010);
                18: check("rt_e18_idle",   obs(1), 8'b11111_000);
                default: ;
            endcase
        end
        check("rt_done_count", done_cnt, 1);

        // Rise on the completing edge chains straight into a new sequence.
        for (int n = 0; n <= 25; n++) begin
            cyc(0, (n == 0) || (n == 12), 1'b1);
            case (n)
                11: check("co_e11",      obs(0), 8'b01111_100);
                12: check("co_e12_done", obs(0), 8'b11111_110);
                13: check("co_e13",      obs(0), 8'b11111_100);
                14: check("co_e14_tap0", obs(0), 8'b11110_100);
                24: check("co_e24_done", obs(0), 8'b11111_010);
                25: check("co_e25_idle", obs(0), 8'b11111_000);
                default: ;
            endcase
        end

        // Two-stage synchroniser: disabled rise ignored, enabled rise shifted by 2.
        act_cnt = 0;
        for (int n = 0; n < 6; n++) begin
            cyc(2, 1'b1, 1'b0);
            act_cnt += activity(2);
        end
        for (int n = 0; n < 4; n++) begin
            cyc(2, 1'b0, 1'b1);
            act_cnt += activity(2);
        end
        check("sync_disabled_quiet", act_cnt, 0);
        for (int n = 0; n <= 15; n++) begin
            cyc(2, 1'b1, 1'b1);
            case (n)
                1:  check("sync_t1_idle",  obs(2), 8'b11111_000);
                2:  check("sync_t2_start", obs(2), 8'b11111_100);
                4:  check("sync_t4_tap0",  obs(2), 8'b11110_100);
                12: check("sync_t12_tap4", obs(2), 8'b01111_100);
                14: check("sync_t14_done", obs(2), 8'b11111_010);
                15: check("sync_t15_idle", obs(2), 8'b11111_000);
                default: ;
            endcase
        end
        trig_v[2] = 1'b0;

        // Asynchronous reset mid-sequence, trig held high across release.
        for (int n = 0; n <= 6; n++) cyc(0, 1'b1, 1'b1);
        check("rst_pre_e6", obs(0), 8'b11011_100);
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_async", obs(0), 8'b11111_000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        act_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            cyc(0, 1'b1, 1'b1);
            act_cnt += activity(0);
        end
        check("rst_release_quiet", act_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
